// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO result registers.
// It uses shift-add multiply and restoring divide, one bit per cycle, and raises stall while busy.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            is_div, neg_res, neg_rem, dbz;
    logic [XLEN-1:0] den, acc_hi, acc_lo;

    // Operand decode, used only while in PREP
    logic            sign_a, sign_b, in_dbz;
    logic [XLEN-1:0] mag_a, mag_b;

    assign sign_a = op[0] & operand_a[XLEN-1];
    assign sign_b = op[0] & operand_b[XLEN-1];
    assign mag_a  = sign_a ? -operand_a : operand_a;
    assign mag_b  = sign_b ? -operand_b : operand_b;
    assign in_dbz = op[1] && (operand_b == '0);

    // acc_hi:acc_lo is the product for multiply, remainder:quotient for divide
    logic [XLEN:0]     msum, dshift, ddiff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign msum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, den} : '0);
    assign dshift   = {acc_hi, acc_lo[XLEN-1]};
    assign ddiff    = dshift - {1'b0, den};
    assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_fix  = neg_res ? -acc_lo : acc_lo;
    assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PREP;
            PREP:    state_nx = in_dbz ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = start ? PREP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == PREP) || (state == CALC) || (state == FIX);
        done        = (state == DONE);
        div_by_zero = (state == DONE) && dbz;
        stall       = busy || (start && ((state == IDLE) || (state == DONE)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dbz     <= 1'b0;
            den     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                PREP: begin
                    is_div  <= op[1];
                    neg_res <= sign_a ^ sign_b;
                    neg_rem <= sign_a;
                    dbz     <= in_dbz;
                    cnt     <= CW'(XLEN);
                    acc_hi  <= '0;
                    if (op[1]) begin
                        den    <= mag_b;
                        acc_lo <= mag_a;
                    end else begin
                        den    <= mag_a;
                        acc_lo <= mag_b;
                    end
                    // Divide by zero skips CALC/FIX and posts its result immediately
                    if (in_dbz) begin
                        hi <= operand_a;
                        lo <= '1;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        if (!ddiff[XLEN]) acc_hi <= ddiff[XLEN-1:0];
                        else              acc_hi <= dshift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], ~ddiff[XLEN]};
                    end else begin
                        acc_hi <= msum[XLEN:1];
                        acc_lo <= {msum[0], acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results and done cycles,
// and a negedge monitor pops and compares them on each done pulse.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("hi", {32'h0, hi}, {32'h0, mon_e.hi});
                chk("lo", {32'h0, lo}, {32'h0, mon_e.lo});
                chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, mon_e.dbz});
            end
        end
    end

    // Issue in cycle 0, hold operands through PREP, then scramble them; returns in cycle 2
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input logic ed,
                            input int lat);
        exp_t e;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        e.cyc = cyc + lat; e.hi = eh; e.lo = el; e.dbz = ed;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=pending_%0d required=0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_stall", {63'h0, stall}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_dbz", {63'h0, div_by_zero}, 64'h0);
        chk("rst_hi", {32'h0, hi}, 64'h0);
        chk("rst_lo", {32'h0, lo}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // MULTU max*max with per-cycle stall/busy profile
        begin
            exp_t e;
            op = MULTU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
            e.cyc = cyc + 35; e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.dbz = 1'b0;
            sb.push_back(e);
            for (int k = 0; k <= 35; k++) begin
                @(negedge clk);
                chk($sformatf("stall_c%0d", k), {63'h0, stall}, {63'h0, (k <= 34)});
                chk($sformatf("busy_c%0d", k), {63'h0, busy}, {63'h0, (k >= 1 && k <= 34)});
                @(posedge clk); #1;
                start = 1'b0;
            end
            drain();
        end

        start_op(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35); drain();
        start_op(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 35); drain();
        start_op(MULT, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 35); drain();
        start_op(MULTU, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 35); drain();
        start_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35); drain();
        start_op(DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 35); drain();
        start_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35); drain();
        start_op(DIVU, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 35); drain();
        start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 35); drain();
        start_op(DIV, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 2); drain();

        // Divide by zero, then a new op started in its DONE cycle
        start_op(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2);
        start_op(MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 35);
        @(negedge clk);
        chk("hold_hi", {32'h0, hi}, 64'h5);
        chk("hold_lo", {32'h0, lo}, 64'hFFFF_FFFF);
        chk("hold_done", {63'h0, done}, 64'h0);
        drain();

        // Reset in cycle 10 of a MULT
        start_op(MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35);
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_stall", {63'h0, stall}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_hi", {32'h0, hi}, 64'h0);
        chk("abort_lo", {32'h0, lo}, 64'h0);
        @(posedge clk); #1;

        // Start pulsed in cycle 5 of a DIVU must be ignored
        start_op(DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 35);
        repeat (3) begin @(posedge clk); #1; end
        op = MULTU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        // Any stray done from the ignored start is reported by the monitor
        repeat (45) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
